// File: rtl/dmem_arbiter_if.sv
// Requester and memory-port signals of the two-port data-memory arbiter.
// The arbiter connects through the slave modport; the requesters and memory side use master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Handshake: a requester raises req with we/addr/wdata stable and holds them
    // until its done pulse; gnt marks ownership from grant through done.
    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, err, rdata, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, err, rdata, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the 16-bit data memory (IDLE -> ACCESS -> DONE).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (req0 first).
module dmem_arbiter #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] TOP_ADDR = 8'hFF
) (
    input  logic          clk,
    input  logic          reset_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              win1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;

    // On contention the requester that was not served last wins.
    always_comb begin
        win1 = bus.req1 && (!bus.req0 || !last_q);
    end
`else
    always_comb begin
        win1 = bus.req1 && !bus.req0;
    end
`endif

    always_comb begin
        sel_we    = win1 ? bus.we1    : bus.we0;
        sel_addr  = win1 ? bus.addr1  : bus.addr0;
        sel_wdata = win1 ? bus.wdata1 : bus.wdata0;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
`ifdef DMEM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d     = S_ACCESS;
                    owner_d     = win1;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    gnt0_d      = !win1;
                    gnt1_d      = win1;
                    busy_d      = 1'b1;
                    // Strobes are registered here so they are high exactly during ACCESS.
                    mem_read_d  = !sel_we && (sel_addr != TOP_ADDR);
                    mem_write_d = sel_we && (sel_addr != TOP_ADDR);
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
`ifdef DMEM_ARB_RR_EN
                    last_d      = win1;
`endif
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                err_d   = (addr_q == TOP_ADDR);
                done0_d = !owner_q;
                done1_d = owner_q;
                if (addr_q == TOP_ADDR) begin
                    rdata_d = '0;
                end else if (!we_q) begin
                    rdata_d = bus.mem_rdata;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory model, directed accesses, done/err/rdata scoreboard.
module tb_dmem_arbiter;
    localparam int W = 18;  // {owner, err, rdata}

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   cyc;
    int   rd_cnt;
    int   wr_cnt;
    logic [7:0]   last_wr_addr;
    logic [15:0]  last_wr_data;
    logic [W-1:0] exp_q[$];
    logic [7:0]   mem[256];
    logic [7:0]   addr_p1;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    dmem_arbiter u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    assign addr_p1       = bus.mem_addr + 8'd1;
    assign bus.mem_rdata = {mem[bus.mem_addr], mem[addr_p1]};

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata[15:8];
            mem[addr_p1]      <= bus.mem_wdata[7:0];
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: strobe bookkeeping and scoreboard pop on every done pulse.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (bus.mem_read || bus.mem_write) begin
            chk("strobe_exclusive", {31'd0, bus.mem_read && bus.mem_write}, 32'd0);
            if (bus.mem_read) rd_cnt++;
            if (bus.mem_write) begin
                wr_cnt++;
                last_wr_addr = bus.mem_addr;
                last_wr_data = bus.mem_wdata;
            end
        end
        if (bus.done0 || bus.done1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", bus.done0, bus.done1);
            end else begin
                e = exp_q.pop_front();
                chk("done_both", {31'd0, bus.done0 && bus.done1}, 32'd0);
                chk("done_owner", {31'd0, bus.done1}, {31'd0, e[17]});
                chk("done_err", {31'd0, bus.err}, {31'd0, e[16]});
                chk("done_rdata", {16'd0, bus.rdata}, {16'd0, e[15:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input bit port, input bit val, input bit we,
                             input logic [7:0] addr, input logic [15:0] wd);
        if (port) begin
            bus.req1 = val; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end else begin
            bus.req0 = val; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end
    endtask

    task automatic do_access(input bit port, input bit we, input logic [7:0] addr,
                             input logic [15:0] wd, input bit e_err, input logic [15:0] e_rd);
        int rd0;
        int wr0;
        bit seen;
        rd0  = rd_cnt;
        wr0  = wr_cnt;
        seen = 1'b0;
        exp_q.push_back({port, e_err, e_rd});
        @(negedge clk);
        drive_req(port, 1'b1, we, addr, wd);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (port ? bus.done1 : bus.done0) seen = 1'b1;
        end
        drive_req(port, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("access_done_seen", {31'd0, seen}, 32'd1);
        chk("write_strobes", wr_cnt - wr0, (we && !e_err) ? 32'd1 : 32'd0);
        chk("read_strobes", rd_cnt - rd0, (!we && !e_err) ? 32'd1 : 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {24'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.busy,
                   bus.mem_read, bus.mem_write}, 32'd0);
        chk({name, "_rdata"}, {16'd0, bus.rdata}, 32'd0);
        chk({name, "_maddr"}, {24'd0, bus.mem_addr}, 32'd0);
        chk({name, "_mwdata"}, {16'd0, bus.mem_wdata}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  prev;
        bit  seen;
        total = 0; bad = 0; cyc = 0; rd_cnt = 0; wr_cnt = 0;
        last_wr_addr = 8'h00; last_wr_data = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[0] = 8'h56;
        mem[1] = 8'h38;
        reset_n = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        reset_n = 1'b1;
        @(negedge clk);

        // Read 0x00 with cycle-exact timing.
        exp_q.push_back({1'b0, 1'b0, 16'h5638});
        drive_req(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        chk("rd_gnt0", {31'd0, bus.gnt0}, 32'd1);
        chk("rd_mem_read", {31'd0, bus.mem_read}, 32'd1);
        chk("rd_mem_addr", {24'd0, bus.mem_addr}, 32'h00);
        chk("rd_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("rd_done0", {31'd0, bus.done0}, 32'd1);
        chk("rd_gnt0_in_done", {31'd0, bus.gnt0}, 32'd1);
        chk("rd_mem_read_off", {31'd0, bus.mem_read}, 32'd0);
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        chk("rd_busy_low", {31'd0, bus.busy}, 32'd0);
        chk("rd_gnt0_low", {31'd0, bus.gnt0}, 32'd0);

        // Contention: both requesters hold req for six accesses.
        for (int k = 0; k < 6; k++) begin
`ifdef DMEM_ARB_RR_EN
            if (k % 2 == 0) exp_q.push_back({1'b1, 1'b0, 16'h2021});
            else            exp_q.push_back({1'b0, 1'b0, 16'h5638});
`else
            exp_q.push_back({1'b0, 1'b0, 16'h5638});
`endif
        end
        drive_req(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
        drive_req(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000);
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (bus.done0 || bus.done1) seen = 1'b1;
            end
            chk("cont_done_seen", {31'd0, seen}, 32'd1);
            if (k > 0) chk("cont_spacing", cyc - prev, 32'd3);
            prev = cyc;
        end
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);

        // Write by requester 1, then read back.
        do_access(1'b1, 1'b1, 8'h20, 16'hCAFE, 1'b0, 16'h5638);
        chk("wr_mem_addr", {24'd0, last_wr_addr}, 32'h20);
        chk("wr_mem_wdata", {16'd0, last_wr_data}, 32'hCAFE);
        do_access(1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 16'hCAFE);

        // Boundary: top address is rejected, the one below is fine.
        do_access(1'b0, 1'b0, 8'hFF, 16'h0000, 1'b1, 16'h0000);
        do_access(1'b0, 1'b0, 8'hFE, 16'h0000, 1'b0, 16'hFEFF);

        // Late request: req1 rises during requester 0's ACCESS.
        exp_q.push_back({1'b0, 1'b0, 16'h5638});
        exp_q.push_back({1'b1, 1'b0, 16'hCAFE});
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        drive_req(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000);
        chk("late_gnt0_access", {31'd0, bus.gnt0}, 32'd1);
        chk("late_gnt1_access", {31'd0, bus.gnt1}, 32'd0);
        @(negedge clk);
        chk("late_done0", {31'd0, bus.done0}, 32'd1);
        chk("late_gnt1_done", {31'd0, bus.gnt1}, 32'd0);
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        chk("late_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("late_idle_gnt1", {31'd0, bus.gnt1}, 32'd0);
        @(negedge clk);
        chk("late_gnt1", {31'd0, bus.gnt1}, 32'd1);
        chk("late_gnt0_off", {31'd0, bus.gnt0}, 32'd0);
        @(negedge clk);
        chk("late_done1", {31'd0, bus.done1}, 32'd1);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);

        // Reset during the ACCESS of a write to 0x30.
        @(negedge clk);
        drive_req(1'b1, 1'b1, 1'b1, 8'h30, 16'h1234);
        @(negedge clk);
        chk("rst_pre_mem_write", {31'd0, bus.mem_write}, 32'd1);
        chk("rst_pre_gnt1", {31'd0, bus.gnt1}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_busy_after", {31'd0, bus.busy}, 32'd0);
        chk("rst_mem_not_written", {24'd0, mem[8'h30]}, 32'h30);
        chk_all_zero("rst_idle");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
